mandel_view_ctrl: RTL

Frame-synchronous view controller for the Mandelbrot renderer. It debounces the four board buttons into pan/zoom commands, holds them until the next vertical-sync edge, and then updates the view registers. It then issues a one-cycle start pulse to the renderer and waits for its done flag. It sits between the button inputs and the fractal datapath inside the graphics top level, in the same clock domain as the pixel logic.

---
 rtl/mandel_pkg.sv | 22 ++
 rtl/btn_debounce.sv | 64 ++++++
 rtl/mandel_view_ctrl.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/mandel_pkg.sv
// mandel_pkg
// Shared definitions for the Mandelbrot view controller: controller state
// encoding, zoom register width and the bit position of each board button
// inside the button vectors.
package mandel_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_VSYNC,
    START,
    RENDER
  } view_state_e;

  localparam int ZOOM_W = 3;

  localparam int NUM_BTNS  = 4;
  localparam int BTN_LEFT  = 0;
  localparam int BTN_RIGHT = 1;
  localparam int BTN_ZIN   = 2;
  localparam int BTN_ZOUT  = 3;

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce
// Brings one raw board button into the clock domain through a two-flop
// synchronizer, debounces it and emits a one-cycle pulse on every accepted
// rising edge of the debounced level.
// Ports:
//   i_clk   clock
//   i_rst   synchronous active-high reset (counter and level cleared)
//   i_btn   raw asynchronous button level
//   o_rise  one-cycle pulse when the debounced level goes 0 -> 1
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_btn,
  output logic o_rise
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             rise_q, rise_d;

  // The counter only runs while the synchronized input disagrees with the
  // accepted level; any return to agreement (a bounce) restarts it, so the
  // level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_comb begin
    sync1_d = i_btn;
    sync2_d = sync1_q;
    cnt_d   = '0;
    level_d = level_q;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
    rise_d = level_d & ~level_q;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
    end
  end

  assign o_rise = rise_q;

endmodule

// File: rtl/mandel_view_ctrl.sv
// mandel_view_ctrl
// Frame-synchronous view controller for the Mandelbrot renderer. Debounced
// button presses are latched as sticky pending events, applied together to
// the view registers at the next vertical-sync rising edge, and followed by a
// one-cycle render start pulse; the controller then waits for render done.
// Ports:
//   i_clk          pixel clock
//   i_rst          synchronous active-high reset
//   i_v_sync       vertical sync level (rising edge = frame boundary)
//   btn0..btn3     raw buttons: pan left, pan right, zoom in, zoom out
//   i_render_done  renderer finished (level, only looked at in RENDER)
//   o_start        one-cycle render start pulse
//   o_center_x     signed view centre x
//   o_zoom         zoom level 0..ZOOM_MAX
//   o_busy         high while starting or rendering
module mandel_view_ctrl
  import mandel_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int COORD_W         = 16,
  parameter int PAN_STEP        = 4096,
  parameter int ZOOM_MAX        = 7
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_v_sync,
  input  logic               btn0,
  input  logic               btn1,
  input  logic               btn2,
  input  logic               btn3,
  input  logic               i_render_done,
  output logic               o_start,
  output logic [COORD_W-1:0] o_center_x,
  output logic [ZOOM_W-1:0]  o_zoom,
  output logic               o_busy
);

  localparam logic [COORD_W:0]   STEP_EXT = (COORD_W + 1)'(PAN_STEP);
  localparam logic [COORD_W-1:0] CX_MAX   = {1'b0, {(COORD_W - 1){1'b1}}};
  localparam logic [COORD_W-1:0] CX_MIN   = {1'b1, {(COORD_W - 1){1'b0}}};
  localparam logic [ZOOM_W-1:0]  ZOOM_TOP = ZOOM_W'(ZOOM_MAX);

  logic [NUM_BTNS-1:0] btn_raw;
  logic [NUM_BTNS-1:0] btn_rise;

  view_state_e         state_q, state_d;
  logic [NUM_BTNS-1:0] pend_q, pend_d;
  logic                pend_init_q, pend_init_d;
  logic                v_sync_q, v_sync_d;
  logic [COORD_W-1:0]  center_q, center_d;
  logic [ZOOM_W-1:0]   zoom_q, zoom_d;

  logic                vsync_rise;
  logic                apply;
  logic [COORD_W:0]    step;
  logic [COORD_W:0]    center_ext;
  logic [COORD_W:0]    center_sum;
  logic [COORD_W-1:0]  center_new;
  logic [ZOOM_W-1:0]   zoom_new;

  assign btn_raw = {btn3, btn2, btn1, btn0};

  for (genvar gi = 0; gi < NUM_BTNS; gi++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn_debounce (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .i_btn (btn_raw[gi]),
      .o_rise(btn_rise[gi])
    );
  end

  assign vsync_rise = i_v_sync & ~v_sync_q;
  assign apply      = (state_q == WAIT_VSYNC) && vsync_rise;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:       if ((|pend_q) || pend_init_q) state_d = WAIT_VSYNC;
      WAIT_VSYNC: if (vsync_rise) state_d = START;
      START:      state_d = RENDER;
      RENDER:     if (i_render_done) state_d = IDLE;
      default:    state_d = IDLE;
    endcase
  end

  always_comb begin
    o_start = (state_q == START);
    o_busy  = (state_q == START) || (state_q == RENDER);
  end

  // The view update is built one bit wider than the coordinate so that an
  // overflow shows up as the two top bits disagreeing; the sign of the wide
  // result then says which rail to clamp to. Opposing requests cancel.
  always_comb begin
    step       = STEP_EXT >> zoom_q;
    center_ext = {center_q[COORD_W-1], center_q};
    center_sum = center_ext;
    if (pend_q[BTN_RIGHT] && !pend_q[BTN_LEFT]) begin
      center_sum = center_ext + step;
    end else if (pend_q[BTN_LEFT] && !pend_q[BTN_RIGHT]) begin
      center_sum = center_ext - step;
    end

    if (center_sum[COORD_W] != center_sum[COORD_W-1]) begin
      center_new = center_sum[COORD_W] ? CX_MIN : CX_MAX;
    end else begin
      center_new = center_sum[COORD_W-1:0];
    end

    zoom_new = zoom_q;
    if (pend_q[BTN_ZIN] && !pend_q[BTN_ZOUT] && (zoom_q < ZOOM_TOP)) begin
      zoom_new = zoom_q + ZOOM_W'(1);
    end else if (pend_q[BTN_ZOUT] && !pend_q[BTN_ZIN] && (zoom_q != '0)) begin
      zoom_new = zoom_q - ZOOM_W'(1);
    end
  end

  // Pending bits accumulate until the frame boundary consumes them; a press
  // that lands in the very cycle of the apply is kept for the next frame.
  always_comb begin
    v_sync_d    = i_v_sync;
    pend_d      = apply ? btn_rise : (pend_q | btn_rise);
    pend_init_d = apply ? 1'b0 : pend_init_q;
    center_d    = apply ? center_new : center_q;
    zoom_d      = apply ? zoom_new : zoom_q;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pend_q      <= '0;
      pend_init_q <= 1'b1;
      v_sync_q    <= 1'b0;
      center_q    <= '0;
      zoom_q      <= '0;
    end else begin
      pend_q      <= pend_d;
      pend_init_q <= pend_init_d;
      v_sync_q    <= v_sync_d;
      center_q    <= center_d;
      zoom_q      <= zoom_d;
    end
  end

  assign o_center_x = center_q;
  assign o_zoom     = zoom_q;

endmodule
